ctrl_unit_fsm_irq: RTL and testbench

// Second-generation multicycle control FSM for the 8-bit Gumnut-style core. It sequences fetch, decode,

---
 rtl/ctrl_unit_fsm_irq.sv | 205 ++++++++++++++++++++
 tb/tb_ctrl_unit_fsm_irq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit_fsm_irq.sv
// Multicycle control FSM for the 8-bit Gumnut-style core: fetch/decode/execute/memory/write-back
// sequencing with prioritised interrupts, bus-ack timeout and separate data/port strobes.
module ctrl_unit_fsm_irq #(
  parameter int NUM_IRQ     = 4,
  parameter int ACK_TIMEOUT = 15,
  localparam int IRQ_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op_i,
  input  logic [2:0]         func_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               inst_ack_i,
  input  logic               data_ack_i,
  input  logic               port_ack_i,
  output logic               inst_cyc_o,
  output logic               inst_stb_o,
  output logic               data_cyc_o,
  output logic               data_stb_o,
  output logic               data_we_o,
  output logic               port_cyc_o,
  output logic               port_stb_o,
  output logic               port_we_o,
  output logic               ir_we_o,
  output logic               pc_en_o,
  output logic               push_o,
  output logic               pop_o,
  output logic               alu_en_o,
  output logic               flags_we_o,
  output logic               reg_wr_o,
  output logic               int_ack_o,
  output logic [IRQ_W-1:0]   int_vec_o,
  output logic               ie_o,
  output logic               stby_o,
  output logic               bus_err_o
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_INT, S_ERR
  } state_t;

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             ie_d;
  logic [IRQ_W-1:0] vec_d, winner;
  logic             found, pend, waiting, to_hit, any_ack, bus_ack;
  logic             is_alu_imm, is_mem, is_shift, is_alu_reg, is_jump, is_misc;

  always_comb begin
    is_alu_imm = ~op_i[6];
    is_mem     = (op_i[6:5] == 2'b10);
    is_shift   = (op_i[6:4] == 3'b110);
    is_alu_reg = (op_i[6:3] == 4'b1110);
    is_jump    = (op_i[6:2] == 5'b11110);
    is_misc    = (op_i == 7'b1111110);
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (irq_i[i] && !found) begin
        winner = IRQ_W'(i);
        found  = 1'b1;
      end
    end
  end

  assign pend    = ie_o & (|irq_i);
  assign any_ack = inst_ack_i | data_ack_i | port_ack_i;
  assign bus_ack = func_i[1] ? port_ack_i : data_ack_i;
  assign to_hit  = (ACK_TIMEOUT != 0) && (cnt == CNT_LAST);

  always_comb begin
    nxt        = state;
    ie_d       = ie_o;
    vec_d      = int_vec_o;
    waiting    = 1'b0;
    inst_cyc_o = 1'b0;
    inst_stb_o = 1'b0;
    data_cyc_o = 1'b0;
    data_stb_o = 1'b0;
    data_we_o  = 1'b0;
    port_cyc_o = 1'b0;
    port_stb_o = 1'b0;
    port_we_o  = 1'b0;
    ir_we_o    = 1'b0;
    pc_en_o    = 1'b0;
    push_o     = 1'b0;
    pop_o      = 1'b0;
    alu_en_o   = 1'b0;
    flags_we_o = 1'b0;
    reg_wr_o   = 1'b0;
    int_ack_o  = 1'b0;
    stby_o     = 1'b0;
    bus_err_o  = 1'b0;
    unique case (state)
      S_FETCH: begin
        inst_cyc_o = 1'b1;
        inst_stb_o = 1'b1;
        waiting    = 1'b1;
        if (inst_ack_i) begin
          ir_we_o = 1'b1;
          nxt     = S_DECODE;
        end else if (to_hit) begin
          nxt = S_ERR;
        end
      end
      S_DECODE: begin
        if (is_alu_imm || is_alu_reg || is_shift || is_mem) begin
          pc_en_o = 1'b1;
          nxt     = S_EXECUTE;
        end else if (is_misc && func_i[2:1] == 2'b10) begin
          // wait/stby park here; PC advances only on the way into INT
          if (pend) begin
            pc_en_o = 1'b1;
            nxt     = S_INT;
          end else begin
            stby_o = func_i[0];
          end
        end else begin
          pc_en_o = 1'b1;
          push_o  = is_jump & func_i[0];
          pop_o   = is_misc & (func_i[2:1] == 2'b00);
          if (is_misc && (func_i == 3'b001 || func_i == 3'b010)) ie_d = 1'b1;
          if (is_misc && func_i == 3'b011) ie_d = 1'b0;
          nxt = pend ? S_INT : S_FETCH;
        end
      end
      S_EXECUTE, S_MEM: begin
        alu_en_o = (state == S_EXECUTE);
        if (is_mem) begin
          data_cyc_o = ~func_i[1];
          data_stb_o = ~func_i[1];
          data_we_o  = ~func_i[1] & func_i[0];
          port_cyc_o = func_i[1];
          port_stb_o = func_i[1];
          port_we_o  = func_i[1] & func_i[0];
          waiting    = 1'b1;
          if (bus_ack) nxt = func_i[0] ? (pend ? S_INT : S_FETCH) : S_WRITEBACK;
          else if (to_hit) nxt = S_ERR;
          else nxt = S_MEM;
        end else begin
          nxt = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        reg_wr_o   = 1'b1;
        flags_we_o = is_alu_imm | is_alu_reg | is_shift;
        nxt        = pend ? S_INT : S_FETCH;
      end
      S_INT: begin
        int_ack_o = 1'b1;
        push_o    = 1'b1;
        pc_en_o   = 1'b1;
        vec_d     = winner;
        ie_d      = 1'b0;
        nxt       = S_FETCH;
      end
      S_ERR: bus_err_o = 1'b1;
      default: nxt = S_FETCH;
    endcase
    // reset holds the state in FETCH, so its Moore strobes are masked here
    if (!rst) begin
      inst_cyc_o = 1'b0;
      inst_stb_o = 1'b0;
      data_cyc_o = 1'b0;
      data_stb_o = 1'b0;
      data_we_o  = 1'b0;
      port_cyc_o = 1'b0;
      port_stb_o = 1'b0;
      port_we_o  = 1'b0;
      ir_we_o    = 1'b0;
      pc_en_o    = 1'b0;
      push_o     = 1'b0;
      pop_o      = 1'b0;
      alu_en_o   = 1'b0;
      flags_we_o = 1'b0;
      reg_wr_o   = 1'b0;
      int_ack_o  = 1'b0;
      stby_o     = 1'b0;
      bus_err_o  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      ie_o      <= 1'b0;
      int_vec_o <= '0;
      cnt       <= '0;
    end else begin
      state     <= nxt;
      ie_o      <= ie_d;
      int_vec_o <= vec_d;
      if (nxt != state && (nxt == S_FETCH || nxt == S_EXECUTE)) cnt <= '0;
      else if (any_ack) cnt <= '0;
      else if (waiting && ACK_TIMEOUT != 0) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_unit_fsm_irq.sv
// Directed bench for ctrl_unit_fsm_irq: hand-computed strobe vectors per cycle, checked with
// immediate assertions.
module tb_ctrl_unit_fsm_irq;

  logic       clk, rst;
  logic [6:0] op_i;
  logic [2:0] func_i;
  logic [3:0] irq_i;
  logic       inst_ack_i, data_ack_i, port_ack_i;
  logic       inst_cyc_o, inst_stb_o, data_cyc_o, data_stb_o, data_we_o;
  logic       port_cyc_o, port_stb_o, port_we_o, ir_we_o, pc_en_o, push_o, pop_o;
  logic       alu_en_o, flags_we_o, reg_wr_o, int_ack_o, ie_o, stby_o, bus_err_o;
  logic [1:0] int_vec_o;
  logic [17:0] obs;

  int checks = 0;
  int errors = 0;

  localparam logic [17:0] M_ICYC = 18'h20000, M_ISTB = 18'h10000, M_DCYC = 18'h08000,
                          M_DSTB = 18'h04000, M_DWE  = 18'h02000, M_PCYC = 18'h01000,
                          M_PSTB = 18'h00800, M_PWE  = 18'h00400, M_IRWE = 18'h00200,
                          M_PCEN = 18'h00100, M_PUSH = 18'h00080, M_POP  = 18'h00040,
                          M_ALU  = 18'h00020, M_FLG  = 18'h00010, M_RWR  = 18'h00008,
                          M_IACK = 18'h00004, M_STBY = 18'h00002, M_BERR = 18'h00001;
  localparam logic [17:0] E_FETCH = M_ICYC | M_ISTB;
  localparam logic [17:0] E_INT   = M_IACK | M_PUSH | M_PCEN;

  localparam logic [6:0] OP_ALUI = 7'b0000000, OP_ALUR = 7'b1110000,
                         OP_MEM  = 7'b1000000, OP_MISC = 7'b1111110;

  ctrl_unit_fsm_irq #(.NUM_IRQ(4), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .op_i(op_i), .func_i(func_i), .irq_i(irq_i),
    .inst_ack_i(inst_ack_i), .data_ack_i(data_ack_i), .port_ack_i(port_ack_i),
    .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o),
    .data_cyc_o(data_cyc_o), .data_stb_o(data_stb_o), .data_we_o(data_we_o),
    .port_cyc_o(port_cyc_o), .port_stb_o(port_stb_o), .port_we_o(port_we_o),
    .ir_we_o(ir_we_o), .pc_en_o(pc_en_o), .push_o(push_o), .pop_o(pop_o),
    .alu_en_o(alu_en_o), .flags_we_o(flags_we_o), .reg_wr_o(reg_wr_o),
    .int_ack_o(int_ack_o), .int_vec_o(int_vec_o), .ie_o(ie_o),
    .stby_o(stby_o), .bus_err_o(bus_err_o)
  );

  assign obs = {inst_cyc_o, inst_stb_o, data_cyc_o, data_stb_o, data_we_o,
                port_cyc_o, port_stb_o, port_we_o, ir_we_o, pc_en_o, push_o, pop_o,
                alu_en_o, flags_we_o, reg_wr_o, int_ack_o, stby_o, bus_err_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fetch one instruction with an immediate ack; ends in DECODE
  task automatic fetch(input logic [6:0] op, input logic [2:0] fn);
    op_i = op; func_i = fn; inst_ack_i = 1'b1;
    #1 chk("fetch_ack", obs, E_FETCH | M_IRWE);
    tick();
    inst_ack_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; op_i = '0; func_i = '0; irq_i = '0;
    inst_ack_i = 1'b0; data_ack_i = 1'b0; port_ack_i = 1'b0;
    #1 chk("rst_outs", obs, '0);
    chk("rst_ie", 18'(ie_o), 18'd0);
    chk("rst_vec", 18'(int_vec_o), 18'd0);
    tick();
    chk("rst_hold", obs, '0);
    rst = 1'b1;
    #1 chk("rel_fetch", obs, E_FETCH);

    // alu_reg add, all immediate
    fetch(OP_ALUR, 3'b000);
    #1 chk("add_dec", obs, M_PCEN);
    tick(); chk("add_exe", obs, M_ALU);
    tick(); chk("add_wb", obs, M_RWR | M_FLG);
    tick(); chk("add_back", obs, E_FETCH);

    // ldm, data ack on the third MEM cycle
    fetch(OP_MEM, 3'b000);
    #1 chk("ldm_dec", obs, M_PCEN);
    tick(); chk("ldm_exe", obs, M_ALU | M_DCYC | M_DSTB);
    tick(); chk("ldm_mem1", obs, M_DCYC | M_DSTB);
    tick(); chk("ldm_mem2", obs, M_DCYC | M_DSTB);
    tick(); data_ack_i = 1'b1;
    #1 chk("ldm_mem3", obs, M_DCYC | M_DSTB);
    tick(); data_ack_i = 1'b0;
    #1 chk("ldm_wb", obs, M_RWR);
    tick(); chk("ldm_back", obs, E_FETCH);

    // stm, immediate ack, no interrupt pending
    fetch(OP_MEM, 3'b001);
    tick(); data_ack_i = 1'b1;
    #1 chk("stm_exe", obs, M_ALU | M_DCYC | M_DSTB | M_DWE);
    tick(); data_ack_i = 1'b0;
    #1 chk("stm_back", obs, E_FETCH);

    // enai then out with irq 0110
    fetch(OP_MISC, 3'b010);
    #1 chk("enai_dec", obs, M_PCEN);
    tick(); chk("enai_ie", 18'(ie_o), 18'd1);
    fetch(OP_MEM, 3'b011);
    irq_i = 4'b0110;
    #1 chk("out_dec", obs, M_PCEN);
    tick(); port_ack_i = 1'b1;
    #1 chk("out_exe", obs, M_ALU | M_PCYC | M_PSTB | M_PWE);
    tick(); port_ack_i = 1'b0;
    #1 chk("out_int", obs, E_INT);
    tick(); chk("out_vec", 18'(int_vec_o), 18'd1);
    chk("out_ie", 18'(ie_o), 18'd0);
    chk("out_fetch", obs, E_FETCH);
    irq_i = '0;

    // wait with ie=1 and no requests, then irq[3]
    fetch(OP_MISC, 3'b010);
    tick();
    fetch(OP_MISC, 3'b100);
    for (int i = 0; i < 10; i++) begin
      #1 chk("wait_idle", obs, '0);
      tick();
    end
    irq_i = 4'b1000;
    #1 chk("wait_wake", obs, M_PCEN);
    tick(); chk("wait_int", obs, E_INT);
    tick(); chk("wait_vec", 18'(int_vec_o), 18'd3);
    chk("wait_ie", 18'(ie_o), 18'd0);
    irq_i = '0;

    // stby with ie=0: requests are ignored
    fetch(OP_MISC, 3'b101);
    #1 chk("stby_dec", obs, M_STBY);
    irq_i = 4'b0001;
    tick(); chk("stby_masked", obs, M_STBY);
    rst = 1'b0;
    #1 chk("stby_rst", obs, '0);
    tick(); rst = 1'b1; irq_i = '0;

    // fetch timeout: no ack for 15 cycles
    for (int i = 0; i < 14; i++) begin
      #1 chk("to_wait", obs, E_FETCH);
      tick();
    end
    #1 chk("to_last", obs, E_FETCH);
    tick(); chk("to_err", obs, M_BERR);
    inst_ack_i = 1'b1;
    tick(); chk("to_sticky", obs, M_BERR);
    inst_ack_i = 1'b0;
    rst = 1'b0; tick(); rst = 1'b1;

    // ack on the fifteenth cycle wins
    for (int i = 0; i < 14; i++) begin
      #1 tick();
    end
    op_i = OP_ALUI; inst_ack_i = 1'b1;
    #1 chk("to_ack15", obs, E_FETCH | M_IRWE);
    tick(); inst_ack_i = 1'b0;
    #1 chk("to_dec", obs, M_PCEN);
    tick(); tick(); chk("alui_wb", obs, M_RWR | M_FLG);
    tick();

    // reset in the middle of MEM
    fetch(OP_MISC, 3'b010);
    tick();
    fetch(OP_MEM, 3'b000);
    tick(); tick(); chk("mid_mem", obs, M_DCYC | M_DSTB);
    #2 rst = 1'b0;
    #1 chk("mid_rst", obs, '0);
    chk("mid_ie", 18'(ie_o), 18'd0);
    tick(); rst = 1'b1;
    #1 chk("mid_fetch", obs, E_FETCH);
    chk("mid_ie2", 18'(ie_o), 18'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
